alu_op_driver: RTL and testbench

- Initiator side of the ALU interface: accepts operation commands over a valid/ready handshake and drives the ALU operand, operation and flag inputs from registers.
- Waits a programmable settle time, captures the ALU result and output flags, and queues them in a response FIFO.
- Keeps an architectural flag register so chained operations (add-with-carry, multi-word shifts) can reuse the previous flags_out as the next flags_in.
- Sits between a command source (CPU-style sequencer or bench) and the combinational ALU.

---
 rtl/alu_op_driver.sv | 214 +++++++++++++++++++++
 tb/tb_alu_op_driver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_driver.sv
// Initiator for a combinational ALU: registers a command onto the ALU inputs, waits a settle time,
// then queues {Z, flags_out} in a response FIFO. Optional counters: define ALU_OP_DRIVER_STATS_EN.
module alu_op_driver #(
  parameter int WIDTH         = 8,
  parameter int FLAGS_W       = 4,
  parameter int OP_W          = 4,
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic               cmd_use_flags,
  input  logic [FLAGS_W-1:0] cmd_flags,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OP_W-1:0]    alu_op,
  output logic [FLAGS_W-1:0] alu_flags_in,
  input  logic [WIDTH-1:0]   alu_z,
  input  logic [FLAGS_W-1:0] alu_flags_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_z,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic [FLAGS_W-1:0] flag_reg,
  output logic               busy
`ifdef ALU_OP_DRIVER_STATS_EN
  ,
  output logic [15:0]        op_count,
  output logic [15:0]        stall_count
`endif
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = WIDTH + FLAGS_W;

  typedef enum logic {
    IDLE,
    SETTLE
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         settle_q, settle_d;
  logic               accept;
  logic               capture;
  logic               pop;

  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic [FLAGS_W-1:0] alu_flags_in_q, alu_flags_in_d;
  logic [FLAGS_W-1:0] flag_reg_q, flag_reg_d;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENTRY_W-1:0] head;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETTLE;
      SETTLE:  if (settle_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready looks only at registered state, so a full FIFO blocks the next accept
  // even if the consumer pops on the same edge.
  always_comb begin
    cmd_ready = (state_q == IDLE) && (cnt_q < CNT_W'(DEPTH));
    busy      = (state_q != IDLE);
    accept    = cmd_valid && cmd_ready;
    capture   = (state_q == SETTLE) && (settle_q == 4'd0);
  end

  always_comb begin
    settle_d = settle_q;
    if (accept) begin
      settle_d = 4'(SETTLE_CYCLES);
    end else if ((state_q == SETTLE) && (settle_q != 4'd0)) begin
      settle_d = settle_q - 4'd1;
    end
  end

  always_comb begin
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    alu_flags_in_d = alu_flags_in_q;
    flag_reg_d     = flag_reg_q;
    if (accept) begin
      alu_a_d        = cmd_a;
      alu_b_d        = cmd_b;
      alu_op_d       = cmd_op;
      alu_flags_in_d = cmd_use_flags ? flag_reg_q : cmd_flags;
    end
    if (capture) begin
      flag_reg_d = alu_flags_out;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      settle_q       <= 4'd0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      alu_flags_in_q <= '0;
      flag_reg_q     <= '0;
    end else begin
      settle_q       <= settle_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      alu_flags_in_q <= alu_flags_in_d;
      flag_reg_q     <= flag_reg_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign alu_flags_in = alu_flags_in_q;
  assign flag_reg     = flag_reg_q;

  // Response FIFO: the slot was reserved when the command was accepted, so capture never overflows.
  assign pop = rsp_valid && rsp_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (capture) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({capture, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= {alu_z, alu_flags_out};
    end
  end

  assign rsp_valid = (cnt_q != '0);
  assign head      = rsp_valid ? mem_q[rd_ptr_q] : '0;
  assign rsp_z     = head[ENTRY_W-1:FLAGS_W];
  assign rsp_flags = head[FLAGS_W-1:0];

`ifdef ALU_OP_DRIVER_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  // Both counters saturate rather than wrap so a long run never reports a small count.
  always_comb begin
    op_count_d    = op_count_q;
    stall_count_d = stall_count_q;
    if (capture && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end
    if (cmd_valid && !cmd_ready && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_count_q    <= 16'd0;
      stall_count_q <= 16'd0;
    end else begin
      op_count_q    <= op_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign op_count    = op_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver with an adder ALU stub and a transaction-level model of
// accepted commands, pending capture time and the response queue.
module tb_alu_op_driver;

  localparam int WIDTH   = 8;
  localparam int FLAGS_W = 4;
  localparam int OP_W    = 4;
  localparam int DEPTH   = 4;
  localparam int SETTLE  = 1;

  logic               clock;
  logic               reset_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic [OP_W-1:0]    cmd_op;
  logic               cmd_use_flags;
  logic [FLAGS_W-1:0] cmd_flags;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [OP_W-1:0]    alu_op;
  logic [FLAGS_W-1:0] alu_flags_in;
  logic [WIDTH-1:0]   alu_z;
  logic [FLAGS_W-1:0] alu_flags_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_z;
  logic [FLAGS_W-1:0] rsp_flags;
  logic [FLAGS_W-1:0] flag_reg;
  logic               busy;
`ifdef ALU_OP_DRIVER_STATS_EN
  logic [15:0]        op_count;
  logic [15:0]        stall_count;
`endif

  int checks = 0;
  int errors = 0;

  alu_op_driver #(
    .WIDTH(WIDTH), .FLAGS_W(FLAGS_W), .OP_W(OP_W), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .cmd_use_flags(cmd_use_flags), .cmd_flags(cmd_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_flags_in(alu_flags_in),
    .alu_z(alu_z), .alu_flags_out(alu_flags_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_flags(rsp_flags),
    .flag_reg(flag_reg), .busy(busy)
`ifdef ALU_OP_DRIVER_STATS_EN
    , .op_count(op_count), .stall_count(stall_count)
`endif
  );

  // Adder ALU stub: Z is the low byte of A+B, flags_out carries the carry in bit 0.
  logic [WIDTH:0] stubSum;
  assign stubSum       = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_z         = stubSum[WIDTH-1:0];
  assign alu_flags_out = {3'b000, stubSum[WIDTH]};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one command in flight, capture due at a known edge, ordered response queue.
  logic [WIDTH-1:0]   mZ[$];
  logic [FLAGS_W-1:0] mF[$];
  bit                 mPending;
  int                 mCapEdge;
  int                 mEdge;
  logic [WIDTH-1:0]   mA, mB;
  logic [OP_W-1:0]    mOp;
  logic [FLAGS_W-1:0] mFin;
  logic [FLAGS_W-1:0] mFlag;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mZ.delete();
      mF.delete();
      mPending = 0;
      mCapEdge = 0;
      mEdge    = 0;
      mA = '0; mB = '0; mOp = '0; mFin = '0; mFlag = '0;
    end else begin
      bit doAccept;
      bit doPop;
      int sum;
      mEdge++;
      doAccept = cmd_valid && !mPending && (mZ.size() < DEPTH);
      doPop    = (mZ.size() > 0) && rsp_ready;
      if (doPop) begin
        void'(mZ.pop_front());
        void'(mF.pop_front());
      end
      if (mPending && (mEdge == mCapEdge)) begin
        sum = int'(mA) + int'(mB);
        mZ.push_back(sum[WIDTH-1:0]);
        mF.push_back((sum > 255) ? 4'h1 : 4'h0);
        mFlag    = (sum > 255) ? 4'h1 : 4'h0;
        mPending = 0;
      end
      if (doAccept) begin
        mA       = cmd_a;
        mB       = cmd_b;
        mOp      = cmd_op;
        mFin     = cmd_use_flags ? mFlag : cmd_flags;
        mPending = 1;
        mCapEdge = mEdge + 1 + SETTLE;
      end
    end
  end

  // Every settled cycle out of reset, all visible outputs must agree with the model.
  always @(negedge clock) begin
    if (reset_n) begin
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(!mPending && (mZ.size() < DEPTH)));
      checkOutput("busy", 32'(busy), 32'(mPending));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(mZ.size() != 0));
      checkOutput("rsp_z", 32'(rsp_z), (mZ.size() != 0) ? 32'(mZ[0]) : 32'h0);
      checkOutput("rsp_flags", 32'(rsp_flags), (mF.size() != 0) ? 32'(mF[0]) : 32'h0);
      checkOutput("flag_reg", 32'(flag_reg), 32'(mFlag));
      checkOutput("alu_a", 32'(alu_a), 32'(mA));
      checkOutput("alu_b", 32'(alu_b), 32'(mB));
      checkOutput("alu_op", 32'(alu_op), 32'(mOp));
      checkOutput("alu_flags_in", 32'(alu_flags_in), 32'(mFin));
    end
  end

  int busyCycles = 0;
  int dutAccepts = 0;
  logic [WIDTH-1:0] popped[$];

  always @(posedge clock) begin
    if (reset_n && busy) busyCycles++;
    if (reset_n && cmd_valid && cmd_ready) dutAccepts++;
    if (reset_n && rsp_valid && rsp_ready) popped.push_back(rsp_z);
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                               input logic useFlags, input logic [3:0] flags);
    bit done;
    done          = 0;
    cmd_valid     = 1'b1;
    cmd_a         = a;
    cmd_b         = b;
    cmd_op        = op;
    cmd_use_flags = useFlags;
    cmd_flags     = flags;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (cmd_ready) done = 1;
      @(posedge clock);
      #1;
    end
    cmd_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (!busy) done = 1;
    end
    if (!done) checkOutput("idle_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (!rsp_valid) done = 1;
    end
    if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
  endtask

  // Directed sequence: reset, single op, carry chain, backpressure, streaming, reset mid-op.
  initial begin
    int base;
    int startBusy;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    cmd_use_flags = 1'b0; cmd_flags = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("idle_flag_reg", 32'(flag_reg), 32'd0);
    checkOutput("idle_alu_a", 32'(alu_a), 32'd0);

    startBusy = busyCycles;
    applyStimulus(8'h12, 8'h34, 4'h0, 1'b0, 4'h0);
    @(posedge clock);
    #1 checkOutput("single_not_yet", 32'(rsp_valid), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single_rsp_z", 32'(rsp_z), 32'h46);
    checkOutput("single_rsp_flags", 32'(rsp_flags), 32'h0);
    @(posedge clock);
    #1 checkOutput("single_busy_cycles", 32'(busyCycles - startBusy), 32'd2);
    drain();

    applyStimulus(8'hFF, 8'h01, 4'h0, 1'b0, 4'hA);
    waitIdle();
    checkOutput("chain_rsp_z", 32'(rsp_z), 32'h00);
    checkOutput("chain_rsp_flags", 32'(rsp_flags), 32'h1);
    checkOutput("chain_flag_reg", 32'(flag_reg), 32'h1);
    applyStimulus(8'h00, 8'h00, 4'h0, 1'b1, 4'h6);
    checkOutput("chain_alu_flags_in", 32'(alu_flags_in), 32'h1);
    waitIdle();
    drain();

    base = popped.size();
    startBusy = dutAccepts;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(8'(k << 4), 8'(k), 4'h1, 1'b0, 4'h0);
    end
    waitIdle();
    cmd_valid = 1'b1; cmd_a = 8'h50; cmd_b = 8'h05; cmd_use_flags = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    checkOutput("bp_accepts", 32'(dutAccepts - startBusy), 32'd4);
    checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    applyStimulus(8'h50, 8'h05, 4'h1, 1'b0, 4'h0);
    applyStimulus(8'h60, 8'h06, 4'h1, 1'b0, 4'h0);
    waitIdle();
    drain();
    checkOutput("bp_pop_count", 32'(popped.size() - base), 32'd6);
    for (int k = 1; k <= 6; k++) begin
      if (popped.size() >= base + k)
        checkOutput("bp_order", 32'(popped[base + k - 1]), 32'(8'h11 * k));
    end

    base = popped.size();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'(i * 17 + 3), 8'(i * 29 + 200), 4'h2, 1'b0, 4'h0);
    end
    waitIdle();
    drain();
    checkOutput("stream_pop_count", 32'(popped.size() - base), 32'd8);
    if (popped.size() > base) checkOutput("stream_first_z", 32'(popped[base]), 32'hCB);

    applyStimulus(8'h01, 8'h02, 4'h0, 1'b0, 4'h0);
    applyStimulus(8'h03, 8'h04, 4'h0, 1'b0, 4'h0);
    waitIdle();
    applyStimulus(8'h80, 8'h90, 4'h0, 1'b0, 4'h0);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_z", 32'(rsp_z), 32'd0);
    checkOutput("rst_flag_reg", 32'(flag_reg), 32'd0);
`ifdef ALU_OP_DRIVER_STATS_EN
    checkOutput("rst_op_count", 32'(op_count), 32'd0);
`endif
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("post_rst_alu_a", 32'(alu_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
